// File: rtl/imem_serial_loader.sv
// Serial program loader for the 10-bit CPU: UART-style receiver feeding instruction RAM, CPU held in reset until done.
// Optional trailing checksum word enabled by defining CHECKSUM_EN.
module imem_serial_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 128,
  parameter int BASE_ADDR    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  output logic       mem_we,
  output logic [9:0] mem_addr,
  output logic [9:0] mem_wdata,
  output logic       cpu_rst,
  output logic       load_done,
  output logic       load_err
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [10:0]   DEPTH_W  = 11'(DEPTH);
  localparam logic [9:0]    BASE_W   = 10'(BASE_ADDR);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {F_LEN, F_DATA, F_CSUM, F_DONE, F_ERR} f_state_t;

  rx_state_t     rx_state;
  f_state_t      f_state;
  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [9:0]    len;
  logic [9:0]    idx;
  logic          bit_end;
  logic          word_valid;
  logic          frame_err;
  logic          last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ser_in;
      sync2 <= sync1;
    end
  end

  // word_valid and frame_err are single-cycle pulses in the stop-bit sample cycle; shreg holds the word then.
  assign bit_end    = (cnt == CNT_FULL);
  assign word_valid = (rx_state == RX_STOP) && bit_end && sync2;
  assign frame_err  = (rx_state == RX_STOP) && bit_end && !sync2;
  assign last_word  = (idx == len - 10'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!sync2) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[9:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [9:0] sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_state   <= F_LEN;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len       <= '0;
      idx       <= '0;
`ifdef CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (f_state)
        F_LEN: begin
          if (frame_err) begin
            f_state <= F_ERR;
          end else if (word_valid) begin
            if (shreg == 10'd0 || {1'b0, shreg} > DEPTH_W) begin
              f_state <= F_ERR;
            end else begin
              len     <= shreg;
              idx     <= '0;
`ifdef CHECKSUM_EN
              sum     <= '0;
`endif
              f_state <= F_DATA;
            end
          end
        end
        F_DATA: begin
          if (frame_err) begin
            f_state <= F_ERR;
          end else if (word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= BASE_W + idx;
            mem_wdata <= shreg;
            idx       <= idx + 10'd1;
`ifdef CHECKSUM_EN
            sum       <= sum + shreg;
            if (last_word) f_state <= F_CSUM;
`else
            if (last_word) f_state <= F_DONE;
`endif
          end
        end
`ifdef CHECKSUM_EN
        F_CSUM: begin
          if (frame_err) begin
            f_state <= F_ERR;
          end else if (word_valid) begin
            f_state <= (shreg == sum) ? F_DONE : F_ERR;
          end
        end
`endif
        F_DONE: begin
          load_done <= 1'b1;
          cpu_rst   <= 1'b0;
        end
        F_ERR: begin
          load_err <= 1'b1;
          cpu_rst  <= 1'b1;
        end
        default: f_state <= F_ERR;
      endcase
    end
  end

endmodule
